// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: mode encodings
// and the configuration helpers used when sizing and checking the pipeline.
// Optional feature macro: PADD_OVF_EN (adds the signed-overflow output).
package adder_pkg;

    // Encodings of the sub input
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Width of the operand slice that a single pipeline stage resolves
    function automatic int chunkWidth(input int n, input int stages);
        return n / stages;
    endfunction

    // The operand width has to split into equal chunks, one per stage
    function automatic bit widthDivisible(input int n, input int stages);
        return (stages > 0) && ((n % stages) == 0);
    endfunction

    // Every stage needs at least one bit of its own to work on
    function automatic bit depthInRange(input int n, input int stages);
        return (stages >= 1) && (stages <= n);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline stage of the add/subtract unit. It resolves operand chunk K
// with a W-bit ripple chain fed by the carry registered in the previous
// stage, and forwards the full operands, the partial result and its own
// carry to the next stage. The stage also owns its slot of the valid chain
// and tells the upstream side whether it can take a new beat.
module adder_stage #(
    parameter int N = 16,
    parameter int W = 4,
    parameter int K = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_sum,
    input  logic         i_carry,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_a,
    output logic [N-1:0] o_b,
    output logic [N-1:0] o_sum,
    output logic         o_carry
);

    logic         r_valid;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [N-1:0] r_sum;
    logic         r_carry;

    logic [W:0]   w_chain;
    logic [W-1:0] w_chunk;
    logic [N-1:0] w_sumNext;
    logic         w_load;

    assign w_chain[0] = i_carry;

    // Ripple chain across this stage's chunk only; the carry into the next
    // chunk is registered, which bounds the per-cycle carry path to W bits.
    for (genvar j = 0; j < W; j++) begin : g_bit
        full_adder u_fa (
            .i_a   (i_a[K*W + j]),
            .i_b   (i_b[K*W + j]),
            .i_cin (w_chain[j]),
            .o_sum (w_chunk[j]),
            .o_cout(w_chain[j+1])
        );
    end

    // The stage can take a new beat when it is empty or its current beat is
    // moving on this cycle; this ripples back from the consumer's ready.
    assign w_load  = !r_valid || i_ready;
    assign o_ready = w_load;

    // Merge the freshly resolved chunk into the partial result
    always_comb begin
        w_sumNext            = i_sum;
        w_sumNext[K*W +: W]  = w_chunk;
    end

    // Valid bit of this slot; a bubble is loaded as readily as a real beat
    // so gaps upstream never hold back the downstream stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= i_valid;
        end
    end

    // Payload registers only change when a real beat arrives, so a stalled
    // last stage keeps its result steady for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_load && i_valid) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_sum   <= w_sumNext;
            r_carry <= w_chain[W];
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_sum   = r_sum;
    assign o_carry = r_carry;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the building block of each stage's ripple chain.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined N-bit add/subtract unit with valid/ready handshakes on both
// sides. The operands are split into STAGES chunks, one chunk resolved per
// stage, with the inter-chunk carry registered between stages.
// Optional feature macro: PADD_OVF_EN adds the registered signed-overflow
// output ovf, aligned with sum.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
`ifdef PADD_OVF_EN
    output logic         cout,
    output logic         ovf
`else
    output logic         cout
`endif
);

    localparam int W = chunkWidth(N, STAGES);

    if (!widthDivisible(N, STAGES) || !depthInRange(N, STAGES)) begin : g_cfgCheck
        $error("pipelined_adder: N must be a multiple of STAGES and 1 <= STAGES <= N");
    end

    // Index k is the input side of stage k; index STAGES is the output of
    // the last stage.
    logic         w_valid [STAGES+1];
    logic         w_load  [STAGES+1];
    logic [N-1:0] w_a     [STAGES+1];
    logic [N-1:0] w_b     [STAGES+1];
    logic [N-1:0] w_sum   [STAGES+1];
    logic         w_carry [STAGES+1];

    logic [N-1:0] w_effB;
    logic         w_effCin;

    // Subtraction is a + ~b + 1, so the mode only changes what enters stage 0
    always_comb begin
        w_effB   = b;
        w_effCin = cin;
        if (sub == SUB) begin
            w_effB   = ~b;
            w_effCin = 1'b1;
        end
    end

    assign w_valid[0]      = in_valid;
    assign w_a[0]          = a;
    assign w_b[0]          = w_effB;
    assign w_sum[0]        = '0;
    assign w_carry[0]      = w_effCin;
    assign w_load[STAGES]  = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .N(N),
            .W(W),
            .K(k)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_valid(w_valid[k]),
            .o_ready(w_load[k]),
            .i_a    (w_a[k]),
            .i_b    (w_b[k]),
            .i_sum  (w_sum[k]),
            .i_carry(w_carry[k]),
            .o_valid(w_valid[k+1]),
            .i_ready(w_load[k+1]),
            .o_a    (w_a[k+1]),
            .o_b    (w_b[k+1]),
            .o_sum  (w_sum[k+1]),
            .o_carry(w_carry[k+1])
        );
    end

    assign in_ready  = w_load[0];
    assign out_valid = w_valid[STAGES];
    assign sum       = w_sum[STAGES];
    assign cout      = w_carry[STAGES];

`ifdef PADD_OVF_EN
    // The last stage already holds the sign bits of A and effective B, so
    // overflow is derived from registers and stays aligned with sum.
    assign ovf = (w_a[STAGES][N-1] == w_b[STAGES][N-1]) &&
                 (w_sum[STAGES][N-1] != w_a[STAGES][N-1]);
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (N=16, STAGES=4).
// Define PADD_OVF_EN to also exercise the overflow output.
module tb_pipelined_adder;

    localparam int N      = 16;
    localparam int STAGES = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
`ifdef PADD_OVF_EN
    logic         ovf;
`endif

    int checks      = 0;
    int errors      = 0;
    int acceptCount = 0;
    int outCount    = 0;

    // {ovf, cout, sum} of each accepted beat, oldest first
    logic [17:0] expQ[$];

    pipelined_adder #(
        .N(N),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
`ifdef PADD_OVF_EN
        .cout     (cout),
        .ovf      (ovf)
`else
        .cout     (cout)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic written from the operation's definition
    function automatic logic [17:0] modelResult(input logic [15:0] ma, input logic [15:0] mb,
                                                input logic mc, input logic ms);
        logic [16:0] full;
        logic [15:0] s;
        logic        c;
        logic        v;
        if (ms) begin
            s = ma - mb;
            c = (ma >= mb);
            v = (ma[15] != mb[15]) && (s[15] != ma[15]);
        end else begin
            full = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
            s = full[15:0];
            c = full[16];
            v = (ma[15] == mb[15]) && (s[15] != ma[15]);
        end
        return {v, c, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample just before the
    // rising edge, scoreboard the handshakes, return at the next falling edge.
    task automatic applyStimulus(input logic v, input logic [15:0] ia, input logic [15:0] ib,
                                 input logic ic, input logic is, input logic ordy);
        logic accepted;
        in_valid  = v;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        out_ready = ordy;
        #1;
        accepted = in_valid && in_ready;
        if (out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                checkOutput("sb_sum", {16'd0, sum}, {16'd0, expQ[0][15:0]});
                checkOutput("sb_cout", {31'd0, cout}, {31'd0, expQ[0][16]});
`ifdef PADD_OVF_EN
                checkOutput("sb_ovf", {31'd0, ovf}, {31'd0, expQ[0][17]});
`endif
                if (out_ready) begin
                    void'(expQ.pop_front());
                    outCount++;
                end
            end
        end
        if (accepted) begin
            expQ.push_back(modelResult(ia, ib, ic, is));
            acceptCount++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    endtask

    // Step idle cycles until a result is presented, bounded
    task automatic waitValid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            idleCycle();
            n++;
        end
        checkOutput(tag, {31'd0, out_valid}, 32'd1);
    endtask

    // Drain all outstanding beats, bounded
    task automatic drain(input string tag);
        for (int i = 0; i < 30 && expQ.size() > 0; i++) begin
            idleCycle();
        end
        checkOutput(tag, expQ.size(), 32'd0);
    endtask

    // Global time limit so the bench can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accBefore;
        int outBefore;

        // Reset state
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #2;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_sum", {16'd0, sum}, 32'd0);
        checkOutput("rst_cout", {31'd0, cout}, 32'd0);
`ifdef PADD_OVF_EN
        checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Latency and carry across every chunk: FFFF + 0001
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i < STAGES; i++) begin
            checkOutput("lat_early", {31'd0, out_valid}, 32'd0);
            idleCycle();
        end
        checkOutput("lat_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("lat_sum", {16'd0, sum}, 32'h0000);
        checkOutput("lat_cout", {31'd0, cout}, 32'd1);
        idleCycle();
        checkOutput("lat_gone", {31'd0, out_valid}, 32'd0);

        // Subtract with borrow then without; cin is ignored in subtract mode
        applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1);
        waitValid("sub1_valid");
        checkOutput("sub1_sum", {16'd0, sum}, 32'hFFFE);
        checkOutput("sub1_cout", {31'd0, cout}, 32'd0);
        idleCycle();
        checkOutput("sub2_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("sub2_sum", {16'd0, sum}, 32'h0002);
        checkOutput("sub2_cout", {31'd0, cout}, 32'd1);
        drain("sub_drain");

        // Add with carry-in, a mixed-chunk pattern
        applyStimulus(1'b1, 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1'b1);
        waitValid("cin_valid");
        checkOutput("cin_sum", {16'd0, sum}, 32'h1001);
        checkOutput("cin_cout", {31'd0, cout}, 32'd0);
        drain("cin_drain");

        // Streaming: 100 back-to-back random beats, mixed add/subtract
        accBefore = acceptCount;
        outBefore = outCount;
        for (int i = 0; i < 100; i++) begin
            checkOutput("stream_in_ready", {31'd0, in_ready}, 32'd1);
            applyStimulus(1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        checkOutput("stream_accepted", acceptCount - accBefore, 32'd100);
        drain("stream_drain");
        checkOutput("stream_results", outCount - outBefore, 32'd100);

        // Backpressure: 10 cycles of offered beats with the consumer stalled
        accBefore = acceptCount;
        outBefore = outCount;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'(16'h1000 + i * 16'h0111), 16'(i * 3), 1'b0, 1'(i % 2), 1'b0);
        end
        checkOutput("bp_accepted", acceptCount - accBefore, STAGES);
        checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_sum_first", {16'd0, sum}, 32'h1000);
        drain("bp_drain");
        checkOutput("bp_results", outCount - outBefore, STAGES);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_no_dup", {31'd0, out_valid}, 32'd0);
            idleCycle();
        end

        // Reset with beats in flight and a result on the output
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'(16'h2222 + i), 16'h0101, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_sum", {16'd0, sum}, 32'd0);
        checkOutput("mid_cout", {31'd0, cout}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expQ.delete();
        #1;
        checkOutput("mid_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i < STAGES; i++) begin
            checkOutput("post_rst_early", {31'd0, out_valid}, 32'd0);
            idleCycle();
        end
        checkOutput("post_rst_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("post_rst_sum", {16'd0, sum}, 32'h2345);
        idleCycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput("post_rst_stale", {31'd0, out_valid}, 32'd0);
            idleCycle();
        end

`ifdef PADD_OVF_EN
        // Signed overflow on add, on subtract, and a clean add
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
        waitValid("ovf1_valid");
        checkOutput("ovf1_sum", {16'd0, sum}, 32'h8000);
        checkOutput("ovf1_ovf", {31'd0, ovf}, 32'd1);
        idleCycle();
        checkOutput("ovf2_sum", {16'd0, sum}, 32'h7FFF);
        checkOutput("ovf2_ovf", {31'd0, ovf}, 32'd1);
        idleCycle();
        checkOutput("ovf3_sum", {16'd0, sum}, 32'h0002);
        checkOutput("ovf3_ovf", {31'd0, ovf}, 32'd0);
        drain("ovf_drain");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
